// File: rtl/input_port_ctrl_if.sv
// Handshake bundle between one router input port, its serial link and the crossbar arbiter.
interface input_port_ctrl_if #(
  parameter int NUM_PORTS = 16,
  parameter int ADDR_W    = $clog2(NUM_PORTS),
  parameter int CNT_W     = 16
);
  logic                 din;
  logic                 frame_n;
  logic [NUM_PORTS-1:0] busy_in;
  logic [NUM_PORTS-1:0] grant_in;
  logic [NUM_PORTS-1:0] request_out;
  logic                 data_enable_out;
  logic [ADDR_W-1:0]    address_out;
  logic                 drop_out;
  logic [CNT_W-1:0]     pkt_count_out;

  modport master (
    output din, frame_n, busy_in, grant_in,
    input  request_out, data_enable_out, address_out, drop_out, pkt_count_out
  );

  modport slave (
    input  din, frame_n, busy_in, grant_in,
    output request_out, data_enable_out, address_out, drop_out, pkt_count_out
  );
endinterface

// File: rtl/input_port_ctrl.sv
// Router input-port controller: deserialises the destination, requests the crossbar,
// forwards payload after grant, drops frames on early end or grant timeout.
module input_port_ctrl #(
  parameter int NUM_PORTS     = 16,
  parameter int ADDR_W        = $clog2(NUM_PORTS),
  parameter int GRANT_TIMEOUT = 64,
  parameter int CNT_W         = 16
) (
  input logic              clk,
  input logic              reset,
  input_port_ctrl_if.slave bus
);

  localparam int TO_W      = (GRANT_TIMEOUT > 0) ? $clog2(GRANT_TIMEOUT + 1) : 1;
  localparam int TO_LAST_I = (GRANT_TIMEOUT > 0) ? GRANT_TIMEOUT - 1 : 0;
  localparam int BIT_START = (ADDR_W > 1) ? ADDR_W - 2 : 0;
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TO_LAST_I);
  localparam logic [ADDR_W-1:0] BIT_INIT = ADDR_W'(BIT_START);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, PAYLOAD, DROP} state_t;

  state_t               state, state_nxt;
  logic [ADDR_W-1:0]    addr, addr_nxt;
  logic [ADDR_W-1:0]    bit_cnt, bit_cnt_nxt;
  logic [TO_W-1:0]      to_cnt, to_cnt_nxt;
  logic                 drop_q, drop_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 cnt_inc;
  logic                 requesting;
  logic                 sel_busy, sel_grant;
  logic [NUM_PORTS-1:0] request;
  logic                 data_enable;

  function automatic logic [NUM_PORTS-1:0] onehot(input logic [ADDR_W-1:0] a);
    logic [NUM_PORTS-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  assign sel_busy  = bus.busy_in[addr];
  assign sel_grant = bus.grant_in[addr];

  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr;
    bit_cnt_nxt = bit_cnt;
    to_cnt_nxt  = to_cnt;
    drop_nxt    = 1'b0;
    cnt_inc     = 1'b0;
    requesting  = 1'b0;
    request     = '0;
    data_enable = 1'b0;
    unique case (state)
      IDLE: begin
        if (!bus.frame_n) begin
          addr_nxt[ADDR_W-1] = bus.din;
          bit_cnt_nxt        = BIT_INIT;
          to_cnt_nxt         = '0;
          state_nxt          = (ADDR_W == 1) ? WAIT : ADDR;
        end
      end
      ADDR: begin
        addr_nxt[bit_cnt] = bus.din;
        bit_cnt_nxt       = bit_cnt - ADDR_W'(1);
        if (bit_cnt == '0) state_nxt = WAIT;
      end
      WAIT: begin
        // A busy destination suppresses the request, and a grant we did not ask for is ignored.
        requesting = !sel_busy;
        request    = requesting ? onehot(addr) : '0;
        to_cnt_nxt = to_cnt + TO_W'(1);
        if (bus.frame_n) begin
          state_nxt = IDLE;
          drop_nxt  = 1'b1;
        end else if (requesting && sel_grant) begin
          state_nxt = PAYLOAD;
        end else if ((GRANT_TIMEOUT != 0) && (to_cnt == TO_LAST)) begin
          state_nxt = DROP;
          drop_nxt  = 1'b1;
        end
      end
      PAYLOAD: begin
        request     = onehot(addr);
        data_enable = 1'b1;
        if (bus.frame_n) begin
          state_nxt = IDLE;
          cnt_inc   = 1'b1;
        end
      end
      DROP: begin
        if (bus.frame_n) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr    <= '0;
      bit_cnt <= '0;
      to_cnt  <= '0;
      drop_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      addr    <= addr_nxt;
      bit_cnt <= bit_cnt_nxt;
      to_cnt  <= to_cnt_nxt;
      drop_q  <= drop_nxt;
      if (cnt_inc) cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.request_out     = request;
  assign bus.data_enable_out = data_enable;
  assign bus.address_out     = addr;
  assign bus.drop_out        = drop_q;
  assign bus.pkt_count_out   = cnt;

endmodule

// File: tb/tb_input_port_ctrl.sv
// Directed bench: a 16-port controller (timeout 8) and a 2-port controller with a 2-bit counter.
module tb_input_port_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  input_port_ctrl_if #(.NUM_PORTS(16), .CNT_W(16)) bus_a ();
  input_port_ctrl_if #(.NUM_PORTS(2),  .CNT_W(2))  bus_b ();

  input_port_ctrl #(.NUM_PORTS(16), .GRANT_TIMEOUT(8), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  input_port_ctrl #(.NUM_PORTS(2), .GRANT_TIMEOUT(64), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic fn, input logic d, input logic [15:0] busy, input logic [15:0] gnt);
    bus_a.frame_n  = fn;
    bus_a.din      = d;
    bus_a.busy_in  = busy;
    bus_a.grant_in = gnt;
    #1;
  endtask

  task automatic drv_b(input logic fn, input logic d, input logic [1:0] busy, input logic [1:0] gnt);
    bus_b.frame_n  = fn;
    bus_b.din      = d;
    bus_b.busy_in  = busy;
    bus_b.grant_in = gnt;
    #1;
  endtask

  task automatic exp_a(input string tag, input logic [15:0] req, input logic en, input logic drp,
                       input logic [15:0] cnt);
    chk({tag, ".req"},  32'(bus_a.request_out),     32'(req));
    chk({tag, ".en"},   32'(bus_a.data_enable_out), 32'(en));
    chk({tag, ".drop"}, 32'(bus_a.drop_out),        32'(drp));
    chk({tag, ".cnt"},  32'(bus_a.pkt_count_out),   32'(cnt));
  endtask

  task automatic exp_b(input string tag, input logic [1:0] req, input logic en, input logic drp,
                       input logic [1:0] cnt);
    chk({tag, ".req"},  32'(bus_b.request_out),     32'(req));
    chk({tag, ".en"},   32'(bus_b.data_enable_out), 32'(en));
    chk({tag, ".drop"}, 32'(bus_b.drop_out),        32'(drp));
    chk({tag, ".cnt"},  32'(bus_b.pkt_count_out),   32'(cnt));
  endtask

  // Address cycles 0..3, MSB first, no busy and no grant.
  task automatic addr_a(input logic [3:0] a);
    for (int i = 3; i >= 0; i--) begin
      drv_a(1'b0, a[i], 16'h0, 16'h0);
      next();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] ec;
    reset = 1'b1;
    drv_a(1'b1, 1'b0, 16'h0, 16'h0);
    drv_b(1'b1, 1'b0, 2'b00, 2'b00);
    next();
    next();
    exp_a("rst_a", 16'h0, 1'b0, 1'b0, 16'd0);
    chk("rst_a.addr", 32'(bus_a.address_out), 32'h0);
    exp_b("rst_b", 2'b00, 1'b0, 1'b0, 2'd0);
    chk("rst_b.addr", 32'(bus_b.address_out), 32'h0);
    reset = 1'b0;

    // Frame to port 10, grant after three padding cycles.
    addr_a(4'hA);
    drv_a(1'b0, 1'b0, 16'h0, 16'h0);    exp_a("t1.c4", 16'h0400, 1'b0, 1'b0, 16'd0);
    chk("t1.addr", 32'(bus_a.address_out), 32'hA);                                    next();
    drv_a(1'b0, 1'b0, 16'h0, 16'h0);    exp_a("t1.c5", 16'h0400, 1'b0, 1'b0, 16'd0); next();
    drv_a(1'b0, 1'b0, 16'h0, 16'h0);    exp_a("t1.c6", 16'h0400, 1'b0, 1'b0, 16'd0); next();
    drv_a(1'b0, 1'b0, 16'h0, 16'h0400); exp_a("t1.c7", 16'h0400, 1'b0, 1'b0, 16'd0); next();
    drv_a(1'b0, 1'b1, 16'h0, 16'h0);    exp_a("t1.c8", 16'h0400, 1'b1, 1'b0, 16'd0); next();
    drv_a(1'b0, 1'b0, 16'h0, 16'h0);    exp_a("t1.c9", 16'h0400, 1'b1, 1'b0, 16'd0); next();
    drv_a(1'b1, 1'b1, 16'h0, 16'h0);    exp_a("t1.c10", 16'h0400, 1'b1, 1'b0, 16'd0); next();
    drv_a(1'b1, 1'b0, 16'h0, 16'h0);    exp_a("t1.c11", 16'h0, 1'b0, 1'b0, 16'd1);   next();

    // Port 5 busy for four WAIT cycles; stray grants are ignored.
    addr_a(4'h5);
    drv_a(1'b0, 1'b0, 16'h0020, 16'h0);    exp_a("t2.c4", 16'h0, 1'b0, 1'b0, 16'd1);    next();
    drv_a(1'b0, 1'b0, 16'h0020, 16'h0008); exp_a("t2.c5", 16'h0, 1'b0, 1'b0, 16'd1);    next();
    drv_a(1'b0, 1'b0, 16'h0020, 16'h0020); exp_a("t2.c6", 16'h0, 1'b0, 1'b0, 16'd1);    next();
    drv_a(1'b0, 1'b0, 16'h0020, 16'h0);    exp_a("t2.c7", 16'h0, 1'b0, 1'b0, 16'd1);    next();
    drv_a(1'b0, 1'b0, 16'h0, 16'h0008);    exp_a("t2.c8", 16'h0020, 1'b0, 1'b0, 16'd1); next();
    drv_a(1'b0, 1'b0, 16'h0, 16'h0020);    exp_a("t2.c9", 16'h0020, 1'b0, 1'b0, 16'd1); next();
    drv_a(1'b1, 1'b1, 16'h0, 16'h0);       exp_a("t2.c10", 16'h0020, 1'b1, 1'b0, 16'd1); next();
    drv_a(1'b1, 1'b0, 16'h0, 16'h0);       exp_a("t2.c11", 16'h0, 1'b0, 1'b0, 16'd2);   next();

    // Grant timeout after exactly eight WAIT cycles, then a normal frame.
    addr_a(4'h3);
    for (int k = 0; k < 8; k++) begin
      drv_a(1'b0, 1'b0, 16'h0, 16'h0);
      exp_a($sformatf("t3.w%0d", k), 16'h0008, 1'b0, 1'b0, 16'd2);
      next();
    end
    drv_a(1'b0, 1'b0, 16'h0, 16'h0);    exp_a("t3.c12", 16'h0, 1'b0, 1'b1, 16'd2); next();
    drv_a(1'b0, 1'b0, 16'h0, 16'h0008); exp_a("t3.c13", 16'h0, 1'b0, 1'b0, 16'd2); next();
    drv_a(1'b1, 1'b0, 16'h0, 16'h0);    exp_a("t3.c14", 16'h0, 1'b0, 1'b0, 16'd2); next();
    addr_a(4'h1);
    drv_a(1'b0, 1'b0, 16'h0, 16'h0002); exp_a("t3.n4", 16'h0002, 1'b0, 1'b0, 16'd2); next();
    drv_a(1'b1, 1'b1, 16'h0, 16'h0);    exp_a("t3.n5", 16'h0002, 1'b1, 1'b0, 16'd2); next();
    drv_a(1'b1, 1'b0, 16'h0, 16'h0);    exp_a("t3.n6", 16'h0, 1'b0, 1'b0, 16'd3);    next();

    // Frame ends during WAIT.
    addr_a(4'h7);
    drv_a(1'b0, 1'b0, 16'h0, 16'h0); exp_a("t4.c4", 16'h0080, 1'b0, 1'b0, 16'd3); next();
    drv_a(1'b1, 1'b0, 16'h0, 16'h0); exp_a("t4.c5", 16'h0080, 1'b0, 1'b0, 16'd3); next();
    drv_a(1'b1, 1'b0, 16'h0, 16'h0); exp_a("t4.c6", 16'h0, 1'b0, 1'b1, 16'd3);    next();
    drv_a(1'b1, 1'b0, 16'h0, 16'h0); exp_a("t4.c7", 16'h0, 1'b0, 1'b0, 16'd3);    next();

    // Back-to-back frames to 15 and 0, then reset in the payload of a frame to 9.
    addr_a(4'hF);
    drv_a(1'b0, 1'b0, 16'h0, 16'h8000); exp_a("t5.a4", 16'h8000, 1'b0, 1'b0, 16'd3); next();
    drv_a(1'b0, 1'b1, 16'h0, 16'h0);    exp_a("t5.a5", 16'h8000, 1'b1, 1'b0, 16'd3); next();
    drv_a(1'b1, 1'b0, 16'h0, 16'h0);    exp_a("t5.a6", 16'h8000, 1'b1, 1'b0, 16'd3); next();
    drv_a(1'b0, 1'b0, 16'h0, 16'h0);    exp_a("t5.b0", 16'h0, 1'b0, 1'b0, 16'd4);    next();
    for (int i = 0; i < 3; i++) begin
      drv_a(1'b0, 1'b0, 16'h0, 16'h0);
      next();
    end
    drv_a(1'b0, 1'b0, 16'h0, 16'h0001); exp_a("t5.b4", 16'h0001, 1'b0, 1'b0, 16'd4);
    chk("t5.b4.addr", 32'(bus_a.address_out), 32'h0);                                 next();
    drv_a(1'b1, 1'b1, 16'h0, 16'h0);    exp_a("t5.b5", 16'h0001, 1'b1, 1'b0, 16'd4); next();
    drv_a(1'b0, 1'b1, 16'h0, 16'h0);    exp_a("t5.c0", 16'h0, 1'b0, 1'b0, 16'd5);    next();
    drv_a(1'b0, 1'b0, 16'h0, 16'h0); next();
    drv_a(1'b0, 1'b0, 16'h0, 16'h0); next();
    drv_a(1'b0, 1'b1, 16'h0, 16'h0); next();
    drv_a(1'b0, 1'b0, 16'h0, 16'h0200); exp_a("t5.c4", 16'h0200, 1'b0, 1'b0, 16'd5); next();
    drv_a(1'b0, 1'b1, 16'h0, 16'h0);    exp_a("t5.c5", 16'h0200, 1'b1, 1'b0, 16'd5); next();
    reset = 1'b1;
    drv_a(1'b0, 1'b0, 16'h0, 16'h0);    exp_a("t5.c6", 16'h0200, 1'b1, 1'b0, 16'd5); next();
    reset = 1'b0;
    drv_a(1'b1, 1'b0, 16'h0, 16'h0);    exp_a("t5.r0", 16'h0, 1'b0, 1'b0, 16'd0);
    chk("t5.r0.addr", 32'(bus_a.address_out), 32'h0);                              next();
    drv_a(1'b1, 1'b0, 16'h0, 16'h0);    exp_a("t5.r1", 16'h0, 1'b0, 1'b0, 16'd0); next();
    addr_a(4'h2);
    drv_a(1'b0, 1'b0, 16'h0, 16'h0004); exp_a("t5.d4", 16'h0004, 1'b0, 1'b0, 16'd0); next();
    drv_a(1'b1, 1'b1, 16'h0, 16'h0);    exp_a("t5.d5", 16'h0004, 1'b1, 1'b0, 16'd0); next();
    drv_a(1'b1, 1'b0, 16'h0, 16'h0);    exp_a("t5.d6", 16'h0, 1'b0, 1'b0, 16'd1);    next();

    // Two-port controller: single address bit, then counter wrap.
    drv_b(1'b0, 1'b1, 2'b00, 2'b00); exp_b("t6.c0", 2'b00, 1'b0, 1'b0, 2'd0); next();
    drv_b(1'b0, 1'b0, 2'b00, 2'b10); exp_b("t6.c1", 2'b10, 1'b0, 1'b0, 2'd0);
    chk("t6.c1.addr", 32'(bus_b.address_out), 32'h1);                          next();
    drv_b(1'b1, 1'b1, 2'b00, 2'b00); exp_b("t6.c2", 2'b10, 1'b1, 1'b0, 2'd0); next();
    drv_b(1'b1, 1'b0, 2'b00, 2'b00); exp_b("t6.c3", 2'b00, 1'b0, 1'b0, 2'd1); next();
    ec = 2'd1;
    for (int k = 0; k < 3; k++) begin
      drv_b(1'b0, 1'b0, 2'b00, 2'b00); next();
      drv_b(1'b0, 1'b0, 2'b00, 2'b01); exp_b($sformatf("t6.f%0d.w", k), 2'b01, 1'b0, 1'b0, ec); next();
      drv_b(1'b1, 1'b1, 2'b00, 2'b00); exp_b($sformatf("t6.f%0d.p", k), 2'b01, 1'b1, 1'b0, ec); next();
      ec = ec + 2'd1;
      drv_b(1'b1, 1'b0, 2'b00, 2'b00); exp_b($sformatf("t6.f%0d.i", k), 2'b00, 1'b0, 1'b0, ec); next();
    end
    chk("t6.wrap", 32'(bus_b.pkt_count_out), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_port_ctrl.md
# input_port_ctrl

Parametrised per-input-port controller for the NxN router. It deserialises the destination address from the serial `din` stream and raises a one-hot request toward the crossbar arbiter, skipping the request while the destination is busy. After grant it enables payload forwarding until end of frame. Over the 16-port controller it adds port-count/address-width parameters, busy-gated requests, a grant timeout with frame drop, and a delivered-packet counter.

## Interface
- `NUM_PORTS`, 16, number of output ports; power of two, ≥ 2
- `ADDR_W`, $clog2(NUM_PORTS), destination address width
- `GRANT_TIMEOUT`, 64, max WAIT cycles without grant before drop; 0 disables timeout
- `CNT_W`, 16, width of delivered-packet counter

- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `din`  in  1  serial address/padding/payload bit
- `frame_n`  in  1  active-low frame marker; high on the last payload bit
- `busy_in`  in  NUM_PORTS  output port busy flags
- `grant_in`  in  NUM_PORTS  arbiter grants, one per output port
- `request_out`  out  NUM_PORTS  one-hot request to arbiter
- `data_enable_out`  out  1  payload bit on `din` valid for forwarding
- `address_out`  out  ADDR_W  captured destination address
- `drop_out`  out  1  one-cycle pulse, frame discarded
- `pkt_count_out`  out  CNT_W  frames fully delivered, wraps modulo 2^CNT_W

## Operation
- States: IDLE, ADDR, WAIT, PAYLOAD, DROP. `addr` register; `bit_cnt` (ADDR_W bits); `to_cnt` ($clog2(GRANT_TIMEOUT+1) bits).
- IDLE: `frame_n`=0 sampled → `addr[ADDR_W-1]`←`din`, `bit_cnt`←ADDR_W-2, go ADDR. If ADDR_W=1, go WAIT directly.
- ADDR: each cycle `addr[bit_cnt]`←`din`, MSB first. After bit 0 is captured → WAIT. `frame_n` is ignored in ADDR.
- WAIT covers padding bits, whose `din` is ignored:
  - `address_out`=`addr`.
  - `request_out`=one-hot(`addr`) when `busy_in[addr]`=0, else all zero.
  - `to_cnt` increments each WAIT cycle.
  - Exits, in priority order:
    1. `frame_n`=1 → IDLE, `drop_out` pulse.
    2. `grant_in[addr]`=1 while requesting → PAYLOAD. Grant without our request is ignored.
    3. GRANT_TIMEOUT≠0 and `to_cnt`=GRANT_TIMEOUT-1 → DROP, `drop_out` pulse.
- PAYLOAD:
  - `data_enable_out`=1, `request_out`=one-hot(`addr`) held regardless of `busy_in`/`grant_in`.
  - `frame_n`=1 sampled → that bit is forwarded (enable high), then IDLE next cycle and `pkt_count_out`+1.
- DROP: all requests 0, enable 0. Wait for `frame_n`=1 sampled → IDLE.
- Back-to-back frames: a new frame may start the cycle after returning to IDLE. Its first address bit is sampled in IDLE.
- Only bits of `grant_in`/`busy_in` indexed by `addr` matter. Others are don't-care.

## Timing
- Reset values:
  - `request_out`=0, `data_enable_out`=0, `address_out`=0, `drop_out`=0, `pkt_count_out`=0.
  - State=IDLE; `addr`, `to_cnt`, `bit_cnt`=0.
- Outputs are Moore functions of registered state plus `addr`. The one exception is `request_out`, which is also gated by the current `busy_in`.
- Cycle 0 = first `frame_n`=0 in IDLE. Address complete at end of cycle ADDR_W-1. WAIT begins at cycle ADDR_W, with the first request the same cycle if not busy.
- Grant sampled at WAIT cycle k → `data_enable_out` high from cycle k+1.
- Frame ending on cycle e → `request_out` drops at e+1, and the counter is updated at e+1.
- `drop_out` is high exactly the one cycle after the decision edge, i.e. the first DROP/IDLE cycle.
- Timeout: with no grant, exactly GRANT_TIMEOUT WAIT cycles elapse before DROP.
- Reset asserted mid-frame → IDLE next edge; no `drop_out`, no count. The remainder of the frame is parsed as new traffic only after `frame_n` is seen low again in IDLE.
- `pkt_count_out` wraps from 2^CNT_W-1 to 0.

## Test plan
- NUM_PORTS=16. `din`=1,0,1,0 with `frame_n`=0, then grant[10] after 3 padding cycles → `address_out`=0xA, `request_out`=0x0400 from cycle 4, enable from cycle 8, `pkt_count_out`=1 after the last bit.
- `busy_in[5]`=1 for 4 WAIT cycles, address 5 → `request_out`=0 during busy, 0x0020 once cleared; grant[3] while waiting on 5 is ignored.
- GRANT_TIMEOUT=8, no grant → 8 WAIT cycles, `drop_out` one pulse, DROP until `frame_n`=1, count unchanged; the next frame is accepted normally.
- `frame_n` goes high during WAIT → single `drop_out`, IDLE, no request left asserted.
- Two back-to-back frames to ports 15 and 0, plus `reset` pulse mid-payload of a third → count=2, all outputs 0 the cycle after reset.
- NUM_PORTS=2 (ADDR_W=1): address bit 1 → request 0b10 at cycle 1; grant → payload; count increments.
